// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, drives the instruction memory address and loads
// the IF/ID register toward decode, with redirect handling and halt-on-marker.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD = 32'hDEAD_BEEF,
    parameter logic [31:0] NOP_WORD  = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_inst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst,
    output logic        halted,
    output logic        misalign_fault,
    output logic [31:0] fetch_count
);

    localparam logic [0:0] RUN  = 1'b0;
    localparam logic [0:0] HALT = 1'b1;

    logic [0:0]  state;
    logic [31:0] pc_p0;
    logic        vld_p1;
    logic [31:0] pc_p1;
    logic [31:0] inst_p1;
    logic        misalign_p1;
    logic [31:0] count_p1;
    logic        advance;

    assign advance = !vld_p1 || id_ready;

    // Stage p0: PC register and same-cycle memory address
    assign imem_addr = pc_p0;

    // Stage p1: IF/ID register toward decode
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            pc_p0       <= {RESET_PC[31:2], 2'b00};
            vld_p1      <= 1'b0;
            pc_p1       <= 32'h0000_0000;
            inst_p1     <= NOP_WORD;
            misalign_p1 <= 1'b0;
            count_p1    <= 32'h0000_0000;
        end else begin
            misalign_p1 <= 1'b0;
            if (redirect_valid) begin
                // The word at the old pc is dropped; it was never counted.
                pc_p0       <= {redirect_target[31:2], 2'b00};
                vld_p1      <= 1'b0;
                inst_p1     <= NOP_WORD;
                state       <= RUN;
                misalign_p1 <= (redirect_target[1:0] != 2'b00);
            end else if (state == RUN) begin
                if (advance) begin
                    vld_p1   <= 1'b1;
                    pc_p1    <= pc_p0;
                    inst_p1  <= imem_inst;
                    count_p1 <= count_p1 + 32'd1;
                    if (imem_inst == HALT_WORD) begin
                        state <= HALT;
                    end else begin
                        pc_p0 <= pc_p0 + 32'd4;
                    end
                end
            end else begin
                // Halted: drain the halt word to decode, then present a bubble.
                if (vld_p1 && id_ready) begin
                    vld_p1  <= 1'b0;
                    inst_p1 <= NOP_WORD;
                end
            end
        end
    end

    assign id_valid       = vld_p1;
    assign id_pc          = pc_p1;
    assign id_inst        = inst_p1;
    assign halted         = (state == HALT);
    assign misalign_fault = misalign_p1;
    assign fetch_count    = count_p1;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: table of per-cycle vectors on one
// instance plus a hand-written wrap/reset sequence on a second instance.
module tb_instruction_fetch;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] HALT = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst, rst2;
    logic [31:0] imem_addr, imem_inst, imem_addr2, imem_inst2;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        id_ready, id_ready2;
    logic        id_valid, id_valid2;
    logic [31:0] id_pc, id_pc2, id_inst, id_inst2;
    logic        halted, halted2, misalign_fault, misalign_fault2;
    logic [31:0] fetch_count, fetch_count2;

    logic [31:0] mem [0:63];
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign imem_inst  = mem[imem_addr[7:2]];
    assign imem_inst2 = mem[imem_addr2[7:2]];

    instruction_fetch dut (
        .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_inst(imem_inst),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .id_ready(id_ready), .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst),
        .halted(halted), .misalign_fault(misalign_fault), .fetch_count(fetch_count)
    );

    instruction_fetch #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
        .clk(clk), .rst(rst2), .imem_addr(imem_addr2), .imem_inst(imem_inst2),
        .redirect_valid(1'b0), .redirect_target(32'h0000_0000),
        .id_ready(id_ready2), .id_valid(id_valid2), .id_pc(id_pc2), .id_inst(id_inst2),
        .halted(halted2), .misalign_fault(misalign_fault2), .fetch_count(fetch_count2)
    );

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        rv;
        logic [31:0] tgt;
        logic        e_vld;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
        logic [31:0] e_addr;
        logic        e_halt;
        logic        e_mis;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic rdy, logic rv, logic [31:0] tgt,
                                logic vld, logic [31:0] pc, logic [31:0] inst,
                                logic [31:0] addr, logic h, logic mis, logic [31:0] cnt);
        vec_t v;
        v.rst = r; v.rdy = rdy; v.rv = rv; v.tgt = tgt;
        v.e_vld = vld; v.e_pc = pc; v.e_inst = inst; v.e_addr = addr;
        v.e_halt = h; v.e_mis = mis; v.e_cnt = cnt;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%08h expected=%08h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] M16 = 32'h1000_0010;
    localparam logic [31:0] I1  = 32'h0010_8093;
    localparam logic [31:0] I2  = 32'h0010_8133;

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + i;
        mem[0] = 32'h0000_0033;
        mem[1] = I1;
        mem[2] = I2;
        mem[3] = HALT;

        //            rst rdy rv tgt           vld pc            inst           addr          h  mis cnt
        // straight-line program into halt, then redirect out of halt
        vecs.push_back(mk(0, 1, 0, 0,          1, 32'h0,  32'h33, 32'h4,  0, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0,          1, 32'h4,  I1,     32'h8,  0, 0, 2));
        vecs.push_back(mk(0, 1, 0, 0,          1, 32'h8,  I2,     32'hC,  0, 0, 3));
        vecs.push_back(mk(0, 1, 0, 0,          1, 32'hC,  HALT,   32'hC,  1, 0, 4));
        vecs.push_back(mk(0, 1, 0, 0,          0, 32'hC,  NOP,    32'hC,  1, 0, 4));
        vecs.push_back(mk(0, 1, 0, 0,          0, 32'hC,  NOP,    32'hC,  1, 0, 4));
        vecs.push_back(mk(0, 0, 1, 32'h40,     0, 32'hC,  NOP,    32'h40, 0, 0, 4));
        vecs.push_back(mk(0, 1, 0, 0,          1, 32'h40, M16,    32'h44, 0, 0, 5));
        // mid-stream reset, then back-pressure
        vecs.push_back(mk(1, 1, 0, 0,          0, 32'h0,  NOP,    32'h0,  0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0,          1, 32'h0,  32'h33, 32'h4,  0, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0,          1, 32'h4,  I1,     32'h8,  0, 0, 2));
        vecs.push_back(mk(0, 0, 0, 0,          1, 32'h4,  I1,     32'h8,  0, 0, 2));
        vecs.push_back(mk(0, 0, 0, 0,          1, 32'h4,  I1,     32'h8,  0, 0, 2));
        vecs.push_back(mk(0, 0, 0, 0,          1, 32'h4,  I1,     32'h8,  0, 0, 2));
        vecs.push_back(mk(0, 1, 0, 0,          1, 32'h8,  I2,     32'hC,  0, 0, 3));
        // redirect while stalled
        vecs.push_back(mk(0, 0, 0, 0,          1, 32'h8,  I2,     32'hC,  0, 0, 3));
        vecs.push_back(mk(0, 0, 1, 32'h40,     0, 32'h8,  NOP,    32'h40, 0, 0, 3));
        vecs.push_back(mk(0, 0, 0, 0,          1, 32'h40, M16,    32'h44, 0, 0, 4));
        // misaligned redirect: one-cycle fault pulse
        vecs.push_back(mk(0, 1, 1, 32'h42,     0, 32'h40, NOP,    32'h40, 0, 1, 4));
        vecs.push_back(mk(0, 1, 0, 0,          1, 32'h40, M16,    32'h44, 0, 0, 5));
        // redirect wins over a halt word being fetched
        vecs.push_back(mk(0, 1, 1, 32'hC,      0, 32'h40, NOP,    32'hC,  0, 0, 5));
        vecs.push_back(mk(0, 1, 1, 32'h40,     0, 32'h40, NOP,    32'h40, 0, 0, 5));
        vecs.push_back(mk(0, 1, 0, 0,          1, 32'h40, M16,    32'h44, 0, 0, 6));
        // halt word held under back-pressure, then drained
        vecs.push_back(mk(0, 1, 1, 32'h8,      0, 32'h40, NOP,    32'h8,  0, 0, 6));
        vecs.push_back(mk(0, 1, 0, 0,          1, 32'h8,  I2,     32'hC,  0, 0, 7));
        vecs.push_back(mk(0, 0, 0, 0,          1, 32'h8,  I2,     32'hC,  0, 0, 7));
        vecs.push_back(mk(0, 1, 0, 0,          1, 32'hC,  HALT,   32'hC,  1, 0, 8));
        vecs.push_back(mk(0, 0, 0, 0,          1, 32'hC,  HALT,   32'hC,  1, 0, 8));
        vecs.push_back(mk(0, 1, 0, 0,          0, 32'hC,  NOP,    32'hC,  1, 0, 8));

        rst = 1'b1; rst2 = 1'b1; id_ready = 1'b0; id_ready2 = 1'b0;
        redirect_valid = 1'b0; redirect_target = 32'h0;
        step();
        rst = 1'b0;
        check("reset_vld",  {31'b0, id_valid}, 32'h0);
        check("reset_pc",   id_pc, 32'h0);
        check("reset_inst", id_inst, NOP);
        check("reset_addr", imem_addr, 32'h0);
        check("reset_halt", {31'b0, halted}, 32'h0);
        check("reset_mis",  {31'b0, misalign_fault}, 32'h0);
        check("reset_cnt",  fetch_count, 32'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst; id_ready = vecs[i].rdy;
            redirect_valid = vecs[i].rv; redirect_target = vecs[i].tgt;
            step();
            check($sformatf("v%0d_vld", i),  {31'b0, id_valid}, {31'b0, vecs[i].e_vld});
            check($sformatf("v%0d_pc", i),   id_pc, vecs[i].e_pc);
            check($sformatf("v%0d_inst", i), id_inst, vecs[i].e_inst);
            check($sformatf("v%0d_addr", i), imem_addr, vecs[i].e_addr);
            check($sformatf("v%0d_halt", i), {31'b0, halted}, {31'b0, vecs[i].e_halt});
            check($sformatf("v%0d_mis", i),  {31'b0, misalign_fault}, {31'b0, vecs[i].e_mis});
            check($sformatf("v%0d_cnt", i),  fetch_count, vecs[i].e_cnt);
        end
        rst = 1'b0; id_ready = 1'b0; redirect_valid = 1'b0;

        // PC wrap from the top of the address space on the second instance
        check("w_reset_addr", imem_addr2, 32'hFFFF_FFF8);
        rst2 = 1'b0; id_ready2 = 1'b1;
        step();
        check("w0_pc",   id_pc2, 32'hFFFF_FFF8);
        check("w0_inst", id_inst2, 32'h1000_003E);
        step();
        check("w1_pc",   id_pc2, 32'hFFFF_FFFC);
        check("w1_inst", id_inst2, 32'h1000_003F);
        check("w1_addr", imem_addr2, 32'h0000_0000);
        step();
        check("w2_pc",   id_pc2, 32'h0000_0000);
        check("w2_inst", id_inst2, 32'h0000_0033);
        check("w2_addr", imem_addr2, 32'h0000_0004);
        check("w2_cnt",  fetch_count2, 32'd3);
        rst2 = 1'b1;
        step();
        rst2 = 1'b0;
        check("wr_vld",  {31'b0, id_valid2}, 32'h0);
        check("wr_addr", imem_addr2, 32'hFFFF_FFF8);
        check("wr_cnt",  fetch_count2, 32'h0);
        check("wr_inst", id_inst2, NOP);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
